// File: rtl/cdt_resp_pkg.sv
// Shared types and constants for the sub-CDT trigger-line responder.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package cdt_resp_pkg;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_ALIGN,
      CMD_DELTA,
      CMD_TRIG,
      CMD_BAD
   } cmd_e;

   typedef enum logic [2:0] {
      R_IDLE,
      R_WAIT,
      R_Z0,
      R_PTN,
      R_Z1
   } resp_state_e;

   typedef enum logic {
      D_IDLE,
      D_SHIFT
   } dec_state_e;

   localparam logic [3:0]  CODE_ALIGN     = 4'b1010;
   localparam logic [3:0]  CODE_DELTA     = 4'b1001;
   localparam logic [3:0]  CODE_TRIG      = 4'b1000;

   localparam logic [16:0] ALIGN_ET_PTN   = 17'h1_FEFE;
   localparam logic [15:0] ALIGN_VETO_PTN = 16'hFEFE;

   // Map a complete 4-bit line code onto a command; unknown codes are BAD.
   function automatic cmd_e decode_cmd(input logic [3:0] code);
      case (code)
         CODE_ALIGN: return CMD_ALIGN;
         CODE_DELTA: return CMD_DELTA;
         CODE_TRIG:  return CMD_TRIG;
         default:    return CMD_BAD;
      endcase
   endfunction

endpackage

// File: rtl/trig_line_decoder.sv
// Serial trigger-line decoder: collects a 4-bit command whose first bit is the leading 1.
// Latency: cmd_valid/cmd are combinational in the cycle the last bit is on the line.
// Backpressure: none; the line is free-running and the consumer must take every result.
module trig_line_decoder
   import cdt_resp_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic in_live,
   input  logic in_trig,
   output logic cmd_valid,
   output cmd_e cmd
);

   dec_state_e state;
   logic [1:0] bit_cnt;
   logic [2:0] shreg;

   // The last bit completes the code; the responder registers the result on this edge.
   always_comb begin
      cmd_valid = 1'b0;
      cmd       = CMD_NONE;
      if (in_live && state == D_SHIFT && bit_cnt == 2'd2) begin
         cmd_valid = 1'b1;
         cmd       = decode_cmd({shreg, in_trig});
      end
   end

   // Shift FSM: a 1 in IDLE opens a command, three more bits close it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= D_IDLE;
         bit_cnt <= 2'd0;
         shreg   <= 3'd0;
      end else if (!in_live) begin
         state   <= D_IDLE;
         bit_cnt <= 2'd0;
         shreg   <= 3'd0;
      end else begin
         case (state)
            D_IDLE: begin
               if (in_trig) begin
                  state   <= D_SHIFT;
                  bit_cnt <= 2'd0;
                  shreg   <= 3'b001;
               end
            end
            D_SHIFT: begin
               shreg <= {shreg[1:0], in_trig};
               if (bit_cnt == 2'd2) begin
                  state <= D_IDLE;
               end else begin
                  bit_cnt <= bit_cnt + 2'd1;
               end
            end
            default: state <= D_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/cdt_align_responder.sv
// Sub-CDT responder: answers align/delta commands with a zero/pattern/zero frame, else passes data.
// Latency: passthrough 1 cycle; frame Z0 word RESP_DELAY+5 cycles after the command's first bit.
// Backpressure: none; commands decoded while a frame is pending are dropped (status_overrun). TRIG_CNT_EN adds counters.
module cdt_align_responder
   import cdt_resp_pkg::*;
#(
   parameter int unsigned RESP_DELAY = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_live,
   input  logic              in_trig,
   input  logic [16:0]       in_et,
   input  logic [15:0]       in_veto,
   input  logic [15:0]       delta_et_val,
   input  logic [15:0]       delta_veto_ptn,
   output logic [16:0]       out_et,
   output logic [15:0]       out_veto,
   output logic              out_trig,
   output logic              out_frame_busy,
   output logic              status_cmd_err,
   output logic              status_overrun
`ifdef TRIG_CNT_EN
   ,
   output logic [CNT_W-1:0]  cnt_align,
   output logic [CNT_W-1:0]  cnt_delta,
   output logic [CNT_W-1:0]  cnt_trig
`endif
);

   localparam logic [7:0] WAIT_LOAD = 8'(RESP_DELAY);

   logic        cmd_valid;
   cmd_e        cmd;
   logic        frame_cmd;
   resp_state_e state;
   logic [7:0]  wait_cnt;
   logic [16:0] ptn_et;
   logic [15:0] ptn_veto;

   trig_line_decoder u_dec (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_live   (in_live),
      .in_trig   (in_trig),
      .cmd_valid (cmd_valid),
      .cmd       (cmd)
   );

   assign frame_cmd = cmd_valid && (cmd == CMD_ALIGN || cmd == CMD_DELTA);

   // Responder FSM with the frame/passthrough output mux and sticky status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= R_IDLE;
         wait_cnt       <= 8'd0;
         ptn_et         <= 17'd0;
         ptn_veto       <= 16'd0;
         out_et         <= 17'd0;
         out_veto       <= 16'd0;
         out_trig       <= 1'b0;
         out_frame_busy <= 1'b0;
         status_cmd_err <= 1'b0;
         status_overrun <= 1'b0;
      end else if (!in_live) begin
         state          <= R_IDLE;
         wait_cnt       <= 8'd0;
         out_et         <= 17'd0;
         out_veto       <= 16'd0;
         out_trig       <= 1'b0;
         out_frame_busy <= 1'b0;
         status_cmd_err <= 1'b0;
         status_overrun <= 1'b0;
      end else begin
         out_trig <= cmd_valid && (cmd == CMD_TRIG);
         if (cmd_valid && cmd == CMD_BAD) status_cmd_err <= 1'b1;
         if (frame_cmd && out_frame_busy) status_overrun <= 1'b1;
         // Default is passthrough; frame states override the data words below.
         out_et   <= in_et;
         out_veto <= in_veto;
         case (state)
            R_IDLE: begin
               out_frame_busy <= 1'b0;
               // Busy stays high through the Z1 output cycle, so this also drops late commands.
               if (frame_cmd && !out_frame_busy) begin
                  out_frame_busy <= 1'b1;
                  wait_cnt       <= WAIT_LOAD;
                  state          <= (WAIT_LOAD == 8'd0) ? R_Z0 : R_WAIT;
                  if (cmd == CMD_ALIGN) begin
                     ptn_et   <= ALIGN_ET_PTN;
                     ptn_veto <= ALIGN_VETO_PTN;
                  end else begin
                     ptn_et   <= {1'b1, delta_et_val};
                     ptn_veto <= delta_veto_ptn;
                  end
               end
            end
            R_WAIT: begin
               out_frame_busy <= 1'b1;
               wait_cnt       <= wait_cnt - 8'd1;
               if (wait_cnt == 8'd1) state <= R_Z0;
            end
            R_Z0: begin
               out_frame_busy <= 1'b1;
               out_et         <= 17'd0;
               out_veto       <= 16'd0;
               state          <= R_PTN;
            end
            R_PTN: begin
               out_frame_busy <= 1'b1;
               out_et         <= ptn_et;
               out_veto       <= ptn_veto;
               state          <= R_Z1;
            end
            R_Z1: begin
               out_frame_busy <= 1'b1;
               out_et         <= 17'd0;
               out_veto       <= 16'd0;
               state          <= R_IDLE;
            end
            default: begin
               out_frame_busy <= 1'b0;
               state          <= R_IDLE;
            end
         endcase
      end
   end

`ifdef TRIG_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Saturating per-type counters; dropped frames still count, in_live does not clear them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_align <= '0;
         cnt_delta <= '0;
         cnt_trig  <= '0;
      end else if (cmd_valid) begin
         if (cmd == CMD_ALIGN && cnt_align != CNT_MAX) cnt_align <= cnt_align + CNT_W'(1);
         if (cmd == CMD_DELTA && cnt_delta != CNT_MAX) cnt_delta <= cnt_delta + CNT_W'(1);
         if (cmd == CMD_TRIG  && cnt_trig  != CNT_MAX) cnt_trig  <= cnt_trig  + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_cdt_align_responder.sv
// Bench for cdt_align_responder: directed timeline with literal checks, then random traffic.
// Expected outputs come from a cycle-window model of commands and frames.
// Optional counter ports are connected and checked when TRIG_CNT_EN is defined.
module tb_cdt_align_responder;

   localparam int D  = 4;
   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        rst_n, in_live, in_trig;
   logic [16:0] in_et;
   logic [15:0] in_veto, delta_et_val, delta_veto_ptn;
   logic [16:0] out_et;
   logic [15:0] out_veto;
   logic        out_trig, out_frame_busy, status_cmd_err, status_overrun;
`ifdef TRIG_CNT_EN
   logic [CW-1:0] cnt_align, cnt_delta, cnt_trig;
`endif

   cdt_align_responder #(.RESP_DELAY(D), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_live        (in_live),
      .in_trig        (in_trig),
      .in_et          (in_et),
      .in_veto        (in_veto),
      .delta_et_val   (delta_et_val),
      .delta_veto_ptn (delta_veto_ptn),
      .out_et         (out_et),
      .out_veto       (out_veto),
      .out_trig       (out_trig),
      .out_frame_busy (out_frame_busy),
      .status_cmd_err (status_cmd_err),
      .status_overrun (status_overrun)
`ifdef TRIG_CNT_EN
      ,
      .cnt_align      (cnt_align),
      .cnt_delta      (cnt_delta),
      .cnt_trig       (cnt_trig)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- model state ----------------
   logic [16:0] e_et;
   logic [15:0] e_veto;
   logic        e_trig, e_busy, e_err, e_ovr;
   int          e_ca, e_cd, e_ct;
   int          cmd_n;
   logic [3:0]  bits;
   bit          frame_ok;
   int          frame_c;
   logic [16:0] f_et;
   logic [15:0] f_veto;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic bit busy_at(input int n);
      return frame_ok && (n >= frame_c + 4) && (n <= frame_c + 7 + D);
   endfunction

   function automatic int sat(input int v);
      return (v < (1 << CW) - 1) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      e_et = '0; e_veto = '0; e_trig = 0; e_busy = 0; e_err = 0; e_ovr = 0;
      e_ca = 0; e_cd = 0; e_ct = 0;
      cmd_n = 0; bits = '0; frame_ok = 0; frame_c = 0; f_et = '0; f_veto = '0;
   endtask

   // Uses the inputs of cycle n to predict the registered outputs of cycle n+1.
   task automatic model_step(input int n);
      bit got;
      int off;
      if (!rst_n) return;
      if (!in_live) begin
         cmd_n = 0; frame_ok = 0; e_err = 0; e_ovr = 0;
         e_et = '0; e_veto = '0; e_trig = 0; e_busy = 0;
         return;
      end
      got = 0;
      if (cmd_n == 0) begin
         if (in_trig) begin cmd_n = 1; bits = 4'b0001; end
      end else begin
         bits = {bits[2:0], in_trig};
         cmd_n++;
         if (cmd_n == 4) begin got = 1; cmd_n = 0; end
      end
      e_trig = got && (bits == 4'b1000);
      if (got) begin
         case (bits)
            4'b1010: begin
               e_ca = sat(e_ca);
               if (busy_at(n)) e_ovr = 1;
               else begin frame_ok = 1; frame_c = n - 3; f_et = 17'h1_FEFE; f_veto = 16'hFEFE; end
            end
            4'b1001: begin
               e_cd = sat(e_cd);
               if (busy_at(n)) e_ovr = 1;
               else begin frame_ok = 1; frame_c = n - 3; f_et = {1'b1, delta_et_val}; f_veto = delta_veto_ptn; end
            end
            4'b1000: e_ct = sat(e_ct);
            default: e_err = 1;
         endcase
      end
      e_busy = busy_at(n + 1);
      off = n + 1 - (frame_c + 5 + D);
      if (frame_ok && off >= 0 && off <= 2) begin
         e_et   = (off == 1) ? f_et : 17'd0;
         e_veto = (off == 1) ? f_veto : 16'd0;
      end else begin
         e_et   = in_et;
         e_veto = in_veto;
      end
   endtask

   // Hand-derived expectations for the directed timeline (RESP_DELAY = 4).
   task automatic lit_checks(input int n);
      case (n)
         2: begin
            chk("lit_rst_et", 32'(out_et), 32'h0);
            chk("lit_rst_veto", 32'(out_veto), 32'h0);
            chk("lit_rst_busy", 32'(out_frame_busy), 32'h0);
            chk("lit_rst_trig", 32'(out_trig), 32'h0);
         end
         53:  chk("lit_trig_pre", 32'(out_trig), 32'h0);
         54: begin
            chk("lit_trig_pulse", 32'(out_trig), 32'h1);
            chk("lit_trig_nobusy", 32'(out_frame_busy), 32'h0);
         end
         55:  chk("lit_trig_post", 32'(out_trig), 32'h0);
         56:  chk("lit_trig_noerr", 32'(status_cmd_err), 32'h0);
         103: chk("lit_al_busy_pre", 32'(out_frame_busy), 32'h0);
         104: chk("lit_al_busy_on", 32'(out_frame_busy), 32'h1);
         109: begin
            chk("lit_al_z0_et", 32'(out_et), 32'h0);
            chk("lit_al_z0_veto", 32'(out_veto), 32'h0);
         end
         110: begin
            chk("lit_al_ptn_et", 32'(out_et), 32'h1_FEFE);
            chk("lit_al_ptn_veto", 32'(out_veto), 32'hFEFE);
         end
         111: begin
            chk("lit_al_z1_et", 32'(out_et), 32'h0);
            chk("lit_al_busy_last", 32'(out_frame_busy), 32'h1);
         end
         112: begin
            chk("lit_al_pass_et", 32'(out_et), 32'h0_0123);
            chk("lit_al_busy_off", 32'(out_frame_busy), 32'h0);
         end
         209: chk("lit_dl_z0_et", 32'(out_et), 32'h0);
         210: begin
            chk("lit_dl_ptn_et", 32'(out_et), 32'h1_0400);
            chk("lit_dl_ptn_veto", 32'(out_veto), 32'h8001);
         end
         211: chk("lit_dl_z1_et", 32'(out_et), 32'h0);
         254: begin
            chk("lit_bad_err", 32'(status_cmd_err), 32'h1);
            chk("lit_bad_nobusy", 32'(out_frame_busy), 32'h0);
         end
         261: begin
            chk("lit_live_err_clr", 32'(status_cmd_err), 32'h0);
            chk("lit_live_et_zero", 32'(out_et), 32'h0);
         end
         262: chk("lit_live_pass", 32'(out_et), 32'h0_0123);
         308: chk("lit_ovr_set", 32'(status_overrun), 32'h1);
         310: chk("lit_ovr_al_ptn", 32'(out_et), 32'h1_FEFE);
         313: chk("lit_ovr_no_z0", 32'(out_et), 32'h0_0123);
         314: chk("lit_ovr_no_ptn", 32'(out_et), 32'h0_0123);
         410: chk("lit_rst_mid_et", 32'(out_et), 32'h0);
         412: begin
            chk("lit_rst_noz1_et", 32'(out_et), 32'h0_0123);
            chk("lit_rst_busy", 32'(out_frame_busy), 32'h0);
         end
         default: ;
      endcase
   endtask

   // Single compare process: sample mid-cycle, compare, then advance the model.
   initial begin : compare
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         chk("out_et", 32'(out_et), 32'(e_et));
         chk("out_veto", 32'(out_veto), 32'(e_veto));
         chk("out_trig", 32'(out_trig), 32'(e_trig));
         chk("out_frame_busy", 32'(out_frame_busy), 32'(e_busy));
         chk("status_cmd_err", 32'(status_cmd_err), 32'(e_err));
         chk("status_overrun", 32'(status_overrun), 32'(e_ovr));
`ifdef TRIG_CNT_EN
         chk("cnt_align", 32'(cnt_align), 32'(e_ca));
         chk("cnt_delta", 32'(cnt_delta), 32'(e_cd));
         chk("cnt_trig", 32'(cnt_trig), 32'(e_ct));
`endif
         lit_checks(cyc);
         model_step(cyc);
      end
   end

   // ---------------- stimulus ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int n);
      while (cyc < n) next_cycle();
   endtask

   task automatic rand_inputs();
      in_et   = 17'($urandom);
      in_veto = 16'($urandom);
      in_live = ($urandom_range(0, 39) != 0);
      rst_n   = ($urandom_range(0, 699) != 0);
      if ($urandom_range(0, 7) == 0) begin
         delta_et_val   = 16'($urandom);
         delta_veto_ptn = 16'($urandom);
      end
   endtask

   task automatic send(input logic [3:0] code, input bit rnd);
      for (int i = 3; i >= 0; i--) begin
         in_trig = code[i];
         if (rnd) rand_inputs();
         next_cycle();
      end
      in_trig = 1'b0;
   endtask

   initial begin : drive
      int         gap;
      logic [3:0] code;
      rst_n          = 1'b0;
      in_live        = 1'b1;
      in_trig        = 1'b0;
      in_et          = 17'h0_0123;
      in_veto        = 16'h0055;
      delta_et_val   = 16'h0400;
      delta_veto_ptn = 16'h8001;

      goto(3);   rst_n = 1'b1;
      goto(50);  send(4'b1000, 1'b0);
      goto(100); send(4'b1010, 1'b0);
      goto(200); send(4'b1001, 1'b0);
      goto(205); delta_et_val = 16'h7777; delta_veto_ptn = 16'h1111;
      goto(250); send(4'b1100, 1'b0);
      goto(260); in_live = 1'b0;
      next_cycle(); in_live = 1'b1;
      goto(300); send(4'b1010, 1'b0);
      goto(304); send(4'b1001, 1'b0);
      goto(400); send(4'b1010, 1'b0);
      goto(410); rst_n = 1'b0;
      next_cycle(); rst_n = 1'b1;

      goto(500);
      while (cyc < 4000) begin
         gap = $urandom_range(0, 10);
         for (int g = 0; g < gap; g++) begin
            rand_inputs();
            next_cycle();
         end
         case ($urandom_range(0, 3))
            0:       code = 4'b1010;
            1:       code = 4'b1001;
            2:       code = 4'b1000;
            default: code = {1'b1, 3'($urandom_range(0, 7))};
         endcase
         send(code, 1'b1);
      end
      rst_n   = 1'b1;
      in_live = 1'b1;
      goto(cyc + 3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cdt_align_responder.md
# cdt_align_responder

Sub-CDT side responder for the top-CDT trigger line. Decodes the 4-bit serial commands sent on the trigger line (1010 = alignment, 1001 = delta, 1000 = single trigger). Answers alignment and delta commands by injecting a three-word pattern frame (zero, pattern, zero) into its outgoing ET and veto streams; outside frames it passes live data through. The top-CDT time controller measures per-link delay from these frames.

## Interface
Parameters:
- RESP_DELAY, 4: idle cycles between command decode and the first frame word (0..255).
- CNT_W, 16: width of the optional command counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- in_live  in  1  run live; low clears status and forces idle
- in_trig  in  1  serial trigger line from top CDT
- in_et  in  17  local ET word; [16] is_et, [15:0] raw sum
- in_veto  in  16  local veto bits
- delta_et_val  in  16  ET raw value sent in the delta frame
- delta_veto_ptn  in  16  veto word sent in the delta frame
- out_et  out  17  ET stream to top CDT
- out_veto  out  16  veto stream to top CDT
- out_trig  out  1  one-cycle pulse per decoded single trigger
- out_frame_busy  out  1  high while a frame is pending or being sent
- status_cmd_err  out  1  sticky: undefined command code seen
- status_overrun  out  1  sticky: command decoded while out_frame_busy
- cnt_align, cnt_delta, cnt_trig  out  CNT_W  command counters (only with TRIG_CNT_EN)

## Operation
- Decoder states: IDLE, SHIFT.
  - IDLE: in_trig=1 starts a command (bit3=1) and moves to SHIFT.
  - SHIFT: samples 3 more bits, then returns to IDLE.
  - Code 1010 decodes as ALIGN, 1001 as DELTA, 1000 as TRIG. Any other code sets status_cmd_err and is discarded.
  - A 1 on the cycle after the last bit starts a new command.
- Responder states: IDLE, WAIT, Z0, PTN, Z1.
  - ALIGN or DELTA in IDLE latches the command and loads the wait counter with RESP_DELAY.
  - WAIT counts down. With RESP_DELAY=0, WAIT is skipped.
  - Z0 drives zero words, PTN drives the pattern, Z1 drives zero words, then the FSM returns to IDLE.
- Frame patterns:
  - ALIGN: ET 17'h1_FEFE, veto 16'hFEFE.
  - DELTA: ET {1'b1, delta_et_val}, veto delta_veto_ptn.
  - Register values are captured at decode. Changes during a frame have no effect.
- Command during a frame: ALIGN or DELTA decoded while out_frame_busy=1 is dropped and sets status_overrun. TRIG is never blocked.
- Passthrough:
  - Outside Z0/PTN/Z1 with in_live=1: out_et/out_veto = in_et/in_veto of the previous cycle.
  - Live data arriving during a frame is discarded.
- in_live=0: both FSMs go to IDLE, outputs are 0, and status_cmd_err/status_overrun are cleared. Counters are not cleared by in_live. Commands are ignored.
- Reset values: all outputs 0; both FSMs IDLE; counters 0.

## Timing
- Command first bit at cycle c, bits at c..c+3.
  - Decode result is registered at c+4.
  - out_trig pulses at c+4.
- Frame words appear at out_et/out_veto as follows:
  - Z0 at c+5+RESP_DELAY.
  - PTN at c+6+RESP_DELAY.
  - Z1 at c+7+RESP_DELAY.
- out_frame_busy is high from c+4 through c+7+RESP_DELAY inclusive.
- Passthrough latency is 1 cycle. All outputs are registered.
- Counters saturate at 2^CNT_W-1 and never wrap.
- An asynchronous reset mid-frame aborts the frame immediately. Outputs go to 0 while rst_n is low.

## Configuration
- TRIG_CNT_EN defined:
  - cnt_align, cnt_delta and cnt_trig are present.
  - Each increments once per successfully decoded command of its type. Dropped or overrun commands still count.
- TRIG_CNT_EN undefined:
  - The counter ports and logic are omitted.
  - All other behaviour is identical.

## Structure
- Package cdt_resp_pkg holds:
  - Command enum: CMD_NONE, CMD_ALIGN, CMD_DELTA, CMD_TRIG, CMD_BAD.
  - Code constants 4'b1010, 4'b1001, 4'b1000.
  - ALIGN_ET_PTN = 17'h1_FEFE and ALIGN_VETO_PTN = 16'hFEFE.
  - Responder state enum.
- Sub-module trig_line_decoder: serial shift/decode FSM.
  - Outputs a one-cycle cmd_valid and the cmd code.
  - The top level holds the responder FSM, pattern mux and status.

## Test plan
- RESP_DELAY=4, live data in_et=17'h0_0123 constant, send 1010 at c=100 -> out_et 0 at 109, 17'h1_FEFE at 110, 0 at 111, 17'h0_0123 from 112; out_veto 0/FEFE/0 at 109/110/111.
- delta_et_val=16'h0400, delta_veto_ptn=16'h8001, send 1001 at c=200 -> out_et 17'h1_0400 and out_veto 16'h8001 at 210, zeros at 209 and 211.
- Send 1000 at c=50 -> out_trig high only at 54, no frame, status_cmd_err=0.
- Send 1100 -> status_cmd_err=1 and no frame; then drop in_live for one cycle -> status_cmd_err=0.
- Send 1010 at c=300 and 1001 at c=304 -> only the align frame at 309..311 is sent; status_overrun=1.
- Assert rst_n=0 at the PTN cycle -> out_et=0 that cycle; after release the passthrough resumes with no Z1 word.
